// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for param_fifo and its storage sub-module:
//   - default data width and depth
//   - read-mode enum (registered read vs. first-word-fall-through)
//   - width helper functions for the occupancy counter and the pointers
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    // REG_READ  : data_out is a register loaded on each accepted read
    // FWFT_READ : data_out shows the head entry combinationally
    typedef enum logic {
        REG_READ  = 1'b0,
        FWFT_READ = 1'b1
    } fifo_mode_e;

    // Counter must hold every value 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer addresses 0..depth-1; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem
// Dual-port storage for param_fifo: one synchronous write port and one read
// port whose style follows MODE.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   load strobe for the registered read port
//   rd_addr  in   read address
//   rd_data  out  read data (registered for REG_READ, combinational for FWFT)
// The storage array itself is never reset.
// ----------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int         WIDTH = DEF_FIFO_WIDTH,
    parameter int         DEPTH = DEF_FIFO_DEPTH,
    parameter int         AW    = 3,
    parameter fifo_mode_e MODE  = REG_READ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    generate
        if (MODE == FWFT_READ) begin : g_fwft
            // Head entry is always visible; the pop only moves the pointer.
            assign rd_data = mem_q[rd_addr];

            // Reset and load strobe have no role in this read style.
            logic unused_ok;
            assign unused_ok = &{1'b0, rst_n, rd_en};
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;

            // Read-before-write: a same-edge write to rd_addr is not seen here.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q <= '0;
                end else if (rd_en) begin
                    rd_data_q <= mem_q[rd_addr];
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule : fifo_mem

// File: rtl/param_fifo.sv
// ----------------------------------------------------------------------------
// param_fifo
// Single-clock synchronous FIFO with arbitrary depth, programmable
// almost-full / almost-empty thresholds, fill-level output, synchronous
// flush and selectable registered or first-word-fall-through read.
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   data_in      in   write data
//   wr_en        in   write request
//   rd_en        in   read request (pop in FWFT mode)
//   flush        in   synchronous clear of pointers/count, beats wr_en/rd_en
//   data_out     out  read data
//   wr_ack       out  previous-cycle write accepted
//   overflow     out  previous-cycle write rejected
//   underflow    out  previous-cycle read rejected
//   full/empty/almostfull/almostempty  out  flags decoded from count
//   count        out  occupancy 0..FIFO_DEPTH
// ----------------------------------------------------------------------------
module param_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH      = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    parameter int FWFT            = 0,
    localparam int CW             = count_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    localparam int         PW   = ptr_width(FIFO_DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FWFT_READ : REG_READ;

    generate
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $fatal(1, "param_fifo: FIFO_DEPTH must be at least 2");
        end
        if (!((ALMOST_EMPTY_TH >= 0) && (ALMOST_EMPTY_TH < ALMOST_FULL_TH) &&
              (ALMOST_FULL_TH <= FIFO_DEPTH))) begin : g_bad_th
            $fatal(1, "param_fifo: need 0 <= ALMOST_EMPTY_TH < ALMOST_FULL_TH <= FIFO_DEPTH");
        end
    endgenerate

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wr_ack_q,    wr_ack_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;

    logic rd_accept;
    logic wr_accept;

    // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Flags depend only on the count register, never on this cycle's requests.
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CW'(ALMOST_FULL_TH));
    assign almostempty = (count_q <= CW'(ALMOST_EMPTY_TH));

    // A read frees a slot, so a full FIFO still takes a write alongside it.
    // An empty FIFO cannot lend its incoming word to a same-cycle read.
    assign rd_accept = rd_en && !empty && !flush;
    assign wr_accept = wr_en && (!full || rd_accept) && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_accept;
        overflow_d  = wr_en && !wr_accept && !flush;
        underflow_d = rd_en && !rd_accept && !flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_accept) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW),
        .MODE  (MODE)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule : param_fifo

// File: tb/tb_param_fifo.sv
// ----------------------------------------------------------------------------
// tb_param_fifo
// Directed bench for param_fifo: instance A is the default 8-deep registered
// read FIFO, instance B is a 5-deep first-word-fall-through FIFO with
// thresholds 1/4.  Inputs change and outputs are sampled 1 ns after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_param_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance A
    logic [15:0] a_din = '0;
    logic        a_wr = 1'b0, a_rd = 1'b0, a_fl = 1'b0;
    logic [15:0] a_dout;
    logic        a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
    logic [3:0]  a_cnt;

    // Instance B
    logic [15:0] b_din = '0;
    logic        b_wr = 1'b0, b_rd = 1'b0, b_fl = 1'b0;
    logic [15:0] b_dout;
    logic        b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
    logic [2:0]  b_cnt;

    param_fifo #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (8)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (a_din),
        .wr_en       (a_wr),
        .rd_en       (a_rd),
        .flush       (a_fl),
        .data_out    (a_dout),
        .wr_ack      (a_ack),
        .overflow    (a_ovf),
        .underflow   (a_udf),
        .full        (a_full),
        .empty       (a_empty),
        .almostfull  (a_af),
        .almostempty (a_ae),
        .count       (a_cnt)
    );

    param_fifo #(
        .FIFO_WIDTH      (16),
        .FIFO_DEPTH      (5),
        .ALMOST_FULL_TH  (4),
        .ALMOST_EMPTY_TH (1),
        .FWFT            (1)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (b_din),
        .wr_en       (b_wr),
        .rd_en       (b_rd),
        .flush       (b_fl),
        .data_out    (b_dout),
        .wr_ack      (b_ack),
        .overflow    (b_ovf),
        .underflow   (b_udf),
        .full        (b_full),
        .empty       (b_empty),
        .almostfull  (b_af),
        .almostempty (b_ae),
        .count       (b_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        rst_n = 1'b1;
        check_val("rst_empty", 32'(a_empty), 32'd1);
        check_val("rst_aempty", 32'(a_ae), 32'd1);
        check_val("rst_full", 32'(a_full), 32'd0);
        check_val("rst_afull", 32'(a_af), 32'd0);
        check_val("rst_count", 32'(a_cnt), 32'd0);
        check_val("rst_dout", 32'(a_dout), 32'd0);
        check_val("rst_pulses", {29'd0, a_ack, a_ovf, a_udf}, 32'd0);

        // ---------------- fill 8 ----------------
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1'b1;
            a_din = 16'(i);
            tick();
            check_val($sformatf("fill%0d_ack", i), 32'(a_ack), 32'd1);
            check_val($sformatf("fill%0d_cnt", i), 32'(a_cnt), 32'(i));
            check_val($sformatf("fill%0d_af", i), 32'(a_af), (i >= 7) ? 32'd1 : 32'd0);
            check_val($sformatf("fill%0d_full", i), 32'(a_full), (i == 8) ? 32'd1 : 32'd0);
        end
        a_din = 16'h0009;
        tick();
        check_val("ovf_flag", 32'(a_ovf), 32'd1);
        check_val("ovf_ack", 32'(a_ack), 32'd0);
        check_val("ovf_cnt", 32'(a_cnt), 32'd8);
        a_wr = 1'b0;

        // ---------------- drain 8 ----------------
        for (int i = 1; i <= 8; i++) begin
            a_rd = 1'b1;
            tick();
            check_val($sformatf("drain%0d_dout", i), 32'(a_dout), 32'(i));
            check_val($sformatf("drain%0d_cnt", i), 32'(a_cnt), 32'(8 - i));
        end
        tick();
        check_val("udf_flag", 32'(a_udf), 32'd1);
        check_val("udf_dout", 32'(a_dout), 32'h0008);
        check_val("udf_empty", 32'(a_empty), 32'd1);
        a_rd = 1'b0;
        tick();
        check_val("udf_clear", 32'(a_udf), 32'd0);

        // ---------------- simultaneous while full ----------------
        for (int i = 0; i < 8; i++) begin
            a_wr = 1'b1;
            a_din = 16'(16'h0010 + i);
            tick();
        end
        check_val("sf_full", 32'(a_full), 32'd1);
        a_wr = 1'b1;
        a_rd = 1'b1;
        a_din = 16'h0018;
        tick();
        check_val("sf_cnt", 32'(a_cnt), 32'd8);
        check_val("sf_ack", 32'(a_ack), 32'd1);
        check_val("sf_dout", 32'(a_dout), 32'h0010);
        a_wr = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            a_rd = 1'b1;
            tick();
            check_val($sformatf("sf_rd%0d", i), 32'(a_dout), 32'(16'h0010 + i));
        end
        a_rd = 1'b0;
        check_val("sf_empty", 32'(a_empty), 32'd1);

        // ---------------- simultaneous while empty ----------------
        a_wr = 1'b1;
        a_rd = 1'b1;
        a_din = 16'h0055;
        tick();
        check_val("se_ack", 32'(a_ack), 32'd1);
        check_val("se_udf", 32'(a_udf), 32'd1);
        check_val("se_cnt", 32'(a_cnt), 32'd1);
        check_val("se_dout", 32'(a_dout), 32'h0018);
        a_wr = 1'b0;
        tick();
        check_val("se_rd", 32'(a_dout), 32'h0055);
        check_val("se_cnt0", 32'(a_cnt), 32'd0);
        a_rd = 1'b0;

        // ---------------- flush at count 5 ----------------
        for (int i = 0; i < 5; i++) begin
            a_wr = 1'b1;
            a_din = 16'(16'h0021 + i);
            tick();
        end
        check_val("fl_pre_cnt", 32'(a_cnt), 32'd5);
        a_fl = 1'b1;
        a_din = 16'h0099;
        tick();
        check_val("fl_cnt", 32'(a_cnt), 32'd0);
        check_val("fl_empty", 32'(a_empty), 32'd1);
        check_val("fl_ack", 32'(a_ack), 32'd0);
        check_val("fl_dout", 32'(a_dout), 32'h0055);
        a_fl = 1'b0;
        a_din = 16'h0031;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        check_val("fl_after_rd", 32'(a_dout), 32'h0031);
        check_val("fl_after_cnt", 32'(a_cnt), 32'd0);
        a_rd = 1'b0;

        // ---------------- FWFT instance ----------------
        b_wr = 1'b1;
        b_din = 16'h00AA;
        tick();
        b_wr = 1'b0;
        check_val("fw_dout", 32'(b_dout), 32'h00AA);
        check_val("fw_cnt", 32'(b_cnt), 32'd1);
        check_val("fw_ae", 32'(b_ae), 32'd1);
        tick();
        check_val("fw_hold", 32'(b_dout), 32'h00AA);
        b_rd = 1'b1;
        tick();
        b_rd = 1'b0;
        check_val("fw_pop_empty", 32'(b_empty), 32'd1);

        for (int i = 0; i < 3; i++) begin
            b_wr = 1'b1;
            b_din = 16'(16'h00B0 + i);
            tick();
        end
        check_val("fw_head0", 32'(b_dout), 32'h00B0);
        for (int k = 3; k < 12; k++) begin
            b_wr = 1'b1;
            b_rd = 1'b1;
            b_din = 16'(16'h00B0 + k);
            tick();
            check_val($sformatf("fw_stream%0d", k), 32'(b_dout), 32'(16'h00B0 + k - 2));
            check_val($sformatf("fw_cnt%0d", k), 32'(b_cnt), 32'd3);
        end
        b_rd = 1'b0;
        b_din = 16'h00BC;
        tick();
        b_wr = 1'b0;
        check_val("fw_af", 32'(b_af), 32'd1);
        check_val("fw_full", 32'(b_full), 32'd0);
        check_val("fw_cnt4", 32'(b_cnt), 32'd4);
        check_val("fw_head_keep", 32'(b_dout), 32'h00B9);

        // ---------------- async reset at count 5 ----------------
        for (int i = 0; i < 5; i++) begin
            a_wr = 1'b1;
            a_din = 16'(16'h0041 + i);
            tick();
        end
        check_val("ar_pre_cnt", 32'(a_cnt), 32'd5);
        check_val("ar_pre_ack", 32'(a_ack), 32'd1);
        a_wr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_cnt", 32'(a_cnt), 32'd0);
        check_val("ar_empty", 32'(a_empty), 32'd1);
        check_val("ar_ae", 32'(a_ae), 32'd1);
        check_val("ar_dout", 32'(a_dout), 32'd0);
        check_val("ar_ack", 32'(a_ack), 32'd0);
        check_val("ar_b_cnt", 32'(b_cnt), 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        check_val("ar_post_udf", 32'(a_udf), 32'd1);
        check_val("ar_post_cnt", 32'(a_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_param_fifo

// File: doc/param_fifo.md
# param_fifo

Parametrised single-clock synchronous FIFO, the next generation of the team's 16x8 FIFO. Adds arbitrary (non-power-of-two) depth, programmable almost-full and almost-empty thresholds, a fill-level output, a synchronous flush, and a selectable first-word-fall-through read mode. Sits between a producer and a consumer in the same clock domain. Keeps the existing handshake and status signal set, so the current UVM FIFO environment extends to it directly.

## Interface
- FIFO_WIDTH, 16: data width in bits, ≥1.
- FIFO_DEPTH, 8: number of entries, ≥2, any integer.
- ALMOST_FULL_TH, FIFO_DEPTH-1: almostfull asserts when count ≥ this value.
- ALMOST_EMPTY_TH, 1: almostempty asserts when count ≤ this value.
- FWFT, 0: read mode. 0 = registered read. 1 = first-word-fall-through.
- CW, $clog2(FIFO_DEPTH+1): count width (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- flush  in  1  synchronous clear of contents.
- data_out  out  FIFO_WIDTH  read data.
- wr_ack  out  1  previous-cycle write accepted.
- overflow  out  1  previous-cycle write rejected.
- underflow  out  1  previous-cycle read rejected.
- full, empty, almostfull, almostempty  out  1  status flags.
- count  out  CW  current occupancy, 0..FIFO_DEPTH.

## Operation
- Storage is FIFO_DEPTH words, addressed by wr_ptr and rd_ptr.
  - Pointer width is $clog2(FIFO_DEPTH).
  - Each pointer wraps explicitly from FIFO_DEPTH-1 to 0.
- Read accepted: rd_en && !empty. Increments rd_ptr.
- Write accepted: wr_en && (!full || read accepted).
  - Stores data_in at wr_ptr and increments wr_ptr.
  - When full, a simultaneous read and write both succeed and count is unchanged.
  - When empty, a simultaneous read and write accepts only the write. The read is an underflow.
- count update: +1 for a write only, -1 for a read only, unchanged for both or neither.
- Status flags are combinational from count:
  - full = (count == FIFO_DEPTH)
  - empty = (count == 0)
  - almostfull = (count ≥ ALMOST_FULL_TH); asserted while full.
  - almostempty = (count ≤ ALMOST_EMPTY_TH); asserted while empty.
- Read data, FWFT=0: on an accepted read, data_out is loaded from mem[rd_ptr]. Otherwise data_out holds its value.
- Read data, FWFT=1: data_out = mem[rd_ptr] combinationally.
  - Valid whenever !empty; don't-care while empty.
  - rd_en acts as pop.
- flush has priority over wr_en and rd_en.
  - Next edge: pointers and count go to 0.
  - wr_ack, overflow and underflow go to 0.
  - data_out holds its value when FWFT=0.
  - Memory contents are not cleared.
- Reset (rst_n low), immediately and asynchronously:
  - Pointers, count, data_out, wr_ack, overflow and underflow go to 0.
  - Flags therefore read empty=1, almostempty=1, full=0, almostfull=0.
  - Memory is not reset.
  - Reset mid-transfer discards all contents. The first edge after release behaves as an empty FIFO.
- Elaboration checks:
  - 0 ≤ ALMOST_EMPTY_TH < ALMOST_FULL_TH ≤ FIFO_DEPTH.
  - FIFO_DEPTH ≥ 2.
  - A violation is a fatal error.

## Timing
- All state updates on the rising edge of clk. No combinational path from wr_en or rd_en to any output.
- Write-to-empty-deasserted latency: 1 cycle.
- Write-to-data_out latency:
  - FWFT=1: 1 cycle.
  - FWFT=0: the read is issued in cycle ≥1 after the write, and data appears 1 cycle after the read.
- wr_ack, overflow and underflow are registered single-cycle pulses, valid in the cycle after the request.
  - wr_ack = write accepted.
  - overflow = wr_en && write rejected.
  - underflow = rd_en && read rejected.
  - Back-to-back requests give back-to-back pulses.
- A full-depth stream at one write and one read per cycle sustains 100 % throughput with no bubbles.

## Structure
- fifo_pkg holds:
  - Default constants (FIFO_WIDTH, FIFO_DEPTH).
  - The read-mode enum fifo_mode_e {REG_READ, FWFT_READ}, mapped to FWFT.
  - The count-width helper function.
- One sub-module, fifo_mem:
  - Dual-port storage array with one write port and one read port.
  - Read port is registered or combinational according to FWFT.
- Pointer, count and flag logic live in param_fifo.

## Test plan
- Reset at FIFO_DEPTH=8: after rst_n is released, empty=1, almostempty=1, count=0, data_out=0, and all pulses are 0.
- Fill 8 writes of 0x0001..0x0008:
  - wr_ack pulses on each write.
  - almostfull rises at count=7.
  - full rises at count=8.
  - A 9th write with data 0x0009 gives overflow=1, wr_ack=0 and count=8.
- Drain 8 reads with FWFT=0:
  - data_out = 0x0001..0x0008, each 1 cycle after its rd_en.
  - A 9th read gives underflow=1, with data_out held at 0x0008.
- Simultaneous wr_en and rd_en:
  - When full: both accepted, count stays 8, and the next reads return the old head followed by the new word last.
  - When empty: write accepted, underflow=1, count=1.
- FWFT=1 with FIFO_DEPTH=5 and thresholds 1/4:
  - Write 0x00AA: data_out=0x00AA 1 cycle later, with no rd_en.
  - Run 12 pushes and pops to check pointer wrap at 4→0 and correct ordering.
- Events mid-stream at count=5:
  - flush: count=0 and empty=1 next cycle, wr_en in the same cycle is ignored, and wr_ack=0.
  - rst_n asserted asynchronously between edges: all outputs reach their reset values before the next edge.
